sprite_plotter: RTL
===================

# sprite_plotter

Downstream stage of the maze game controller: it consumes the controller's one-cycle `plot` strobe with `s_color`, `xpos` and `ypos`, and expands each request into a CELL×CELL block of pixel writes for the VGA adapter. A one-deep request buffer holds a second request while a block is still being drawn, so the controller's ERASE and DRAW strobes a few cycles apart are never lost. Every pixel write is registered, at one pixel per clock.

## Interface
- `CELL`, 4: sprite edge in pixels; must be a power of two.
- `XW`, 5: width of the cell x coordinate.
- `YW`, 5: width of the cell y coordinate.
- `X_W`, 8: width of the VGA x coordinate.
- `Y_W`, 7: width of the VGA y coordinate.
- `SCREEN_W`, 160: screen width in pixels.
- `SCREEN_H`, 120: screen height in pixels.
- `COLOR_W`, 3: colour width.
- `FG_COLOR`, 3'b111: player colour.
- `BG_COLOR`, 3'b000: erase colour.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `plot`  in  1  request strobe.
- `s_color`  in  1  colour select: 1 selects FG_COLOR, 0 selects BG_COLOR.
- `xpos`  in  XW  cell x coordinate.
- `ypos`  in  YW  cell y coordinate.
- `vga_x`  out  X_W  pixel x.
- `vga_y`  out  Y_W  pixel y.
- `vga_colour`  out  COLOR_W  pixel colour.
- `vga_plot`  out  1  pixel write enable.
- `busy`  out  1  high while the engine is active or the pending buffer is full.
- `done`  out  1  one-cycle pulse after the last pixel of a block.
- `overflow`  out  1  sticky flag: a request was dropped.

## Operation
- **Pending buffer (PEND):** one entry holding colour, x and y, plus a valid bit.
  - A request with `plot`=1 is accepted into PEND at the clock edge if PEND is empty, or if PEND is being consumed on that same edge.
  - Otherwise the request is dropped and `overflow` is set to 1. It stays 1 until reset.
- **Engine states:**
  - IDLE: if PEND is valid, go to DRAW. The next edge loads base_x = xpos·CELL, base_y = ypos·CELL, sets px = py = 0, latches the colour and clears PEND.
  - DRAW: issue one pixel per cycle in row-major order, px fastest. After px = CELL-1 and py = CELL-1:
    - if PEND is valid, reload directly from PEND and stay in DRAW, with no gap cycle;
    - otherwise go to IDLE.
- **Pixel coordinates:**
  - vga_x = base_x + px and vga_y = base_y + py, computed at X_W+1 and Y_W+1 bits.
  - A pixel with vga_x ≥ SCREEN_W or vga_y ≥ SCREEN_H is clipped: `vga_plot` is 0 for that cycle, but the counters still advance.
- `done` is asserted in the cycle after the final pixel cycle of each block. This holds even when every pixel of the block was clipped.
- `plot` arriving while the engine is in DRAW is legal and is buffered by PEND.
- **Reset (async, including mid-block):**
  - state returns to IDLE; PEND, the counters and `overflow` are cleared;
  - all outputs go to 0: `vga_x`, `vga_y`, `vga_colour`, `vga_plot`, `busy`, `done`, `overflow`.

## Timing
- The request path takes two edges, so the first `vga_plot` is high 2 cycles after `plot` (plot high in cycle T, first write in cycle T+2):
  - edge closing cycle T: PEND is filled;
  - edge closing cycle T+1: the engine loads from PEND;
  - cycle T+2: first pixel write.
- One block occupies CELL² consecutive write cycles: 16 cycles at the default CELL of 4.
- Back-to-back blocks run with zero idle cycles between them.
- `busy` is combinational from registered state. It is high from cycle T+1 until the last write cycle, inclusive.
- Outputs are all registered, with no input-to-output combinational path.

## Configuration
- **`SPRITE_PLOTTER_MASK_EN` defined:** FG_COLOR blocks use a fixed CELL×CELL shape mask from the package.
  - Pixels with mask bit 0 are suppressed (`vga_plot` = 0).
  - BG_COLOR blocks always draw a solid block, so erase is complete.
- **Not defined:** every block is a solid square.
- Timing and `done` behaviour are identical in both builds.

## Structure
- **Package `sprite_plotter_pkg`:** engine state enum (IDLE, DRAW), the default FG/BG colours, SCREEN_W/SCREEN_H constants and the player mask constant.
- **Sub-module `plot_request_buffer`:**
  - holds the PEND register, the accept/consume logic and the `overflow` flag;
  - provides a valid/consume handshake to the engine.

## Test plan
- **Single erase:** reset, then `plot`=1, `s_color`=0, x=2, y=3 for one cycle.
  - Expect 16 writes with vga_x 8..11 and vga_y 12..15 in row-major order, colour 0, the first write at T+2, then `done` for one cycle.
- **Back-to-back:** erase at (2,3), then draw with s_color=1 at (3,3) issued 5 cycles later.
  - Expect 32 contiguous writes, the second 16 at x 12..15 with colour 7, and `overflow`=0.
- **Overflow:** three `plot` pulses on consecutive cycles.
  - Expect the first two blocks to be drawn, the third dropped, `overflow`=1 and still 1 after 100 cycles.
- **Clip:** XW widened to 6, x=40, y=0.
  - Expect base_x 160, all 16 cycles with `vga_plot`=0, and `done` still pulsed.
- **Reset mid-block:** assert `reset` at pixel 5 with PEND full.
  - Expect all outputs to read 0 immediately, no further writes, and a later request to draw normally.
- **Mask, `SPRITE_PLOTTER_MASK_EN` defined:** FG block at (1,1).
  - Expect the write count to equal the mask popcount; a BG block at the same cell gives 16 writes.

Source files
------------

// File: rtl/sprite_plotter_pkg.sv
// Shared types and constants for the sprite plotter: engine states, default colours,
// screen size and the player shape mask used when SPRITE_PLOTTER_MASK_EN is defined.
package sprite_plotter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } eng_state_e;

  localparam logic [2:0] FG_COLOR_DEF  = 3'b111;
  localparam logic [2:0] BG_COLOR_DEF  = 3'b000;
  localparam int         SCREEN_W_DEF  = 160;
  localparam int         SCREEN_H_DEF  = 120;

  // Player shape, bit index = row*MASK_EDGE + col (row 0 is the top row).
  localparam int          MASK_EDGE   = 4;
  localparam logic [15:0] PLAYER_MASK = 16'b1001_0110_1111_0110;

  function automatic logic mask_bit(input logic [31:0] col, input logic [31:0] row);
    logic [3:0] idx;
    idx = 4'((row * MASK_EDGE + col) % (MASK_EDGE * MASK_EDGE));
    return PLAYER_MASK[idx];
  endfunction

endpackage

// File: rtl/plot_request_buffer.sv
// One-deep request buffer in front of the sprite engine; a request is taken when the
// slot is empty or being consumed on the same edge, otherwise it sets the sticky overflow.
module plot_request_buffer #(
  parameter int XW = 5,
  parameter int YW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          plot,
  input  logic          s_color,
  input  logic [XW-1:0] xpos,
  input  logic [YW-1:0] ypos,
  input  logic          consume,
  output logic          pend_valid,
  output logic          pend_color,
  output logic [XW-1:0] pend_x,
  output logic [YW-1:0] pend_y,
  output logic          overflow
);

  logic          valid_q, valid_d;
  logic          color_q, color_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          overflow_q, overflow_d;
  logic          accept;

  always_comb begin
    accept     = plot && (!valid_q || consume);
    valid_d    = valid_q;
    color_d    = color_q;
    x_d        = x_q;
    y_d        = y_q;
    if (consume) valid_d = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      color_d = s_color;
      x_d     = xpos;
      y_d     = ypos;
    end
    overflow_d = overflow_q || (plot && !accept);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      color_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      color_q    <= color_d;
      x_q        <= x_d;
      y_q        <= y_d;
      overflow_q <= overflow_d;
    end
  end

  assign pend_valid = valid_q;
  assign pend_color = color_q;
  assign pend_x     = x_q;
  assign pend_y     = y_q;
  assign overflow   = overflow_q;

endmodule

// File: rtl/sprite_plotter.sv
// Expands cell-sized plot requests into CELL x CELL registered pixel writes, one per clock.
// Optional build macro SPRITE_PLOTTER_MASK_EN: foreground blocks use the package shape mask.
//
// state | meaning
// IDLE  | no block in progress; loads from the request buffer when it is valid
// DRAW  | one pixel per cycle, px fastest; reloads back-to-back from the buffer at the end
module sprite_plotter
  import sprite_plotter_pkg::*;
#(
  parameter int                 CELL     = 4,
  parameter int                 XW       = 5,
  parameter int                 YW       = 5,
  parameter int                 X_W      = 8,
  parameter int                 Y_W      = 7,
  parameter int                 SCREEN_W = SCREEN_W_DEF,
  parameter int                 SCREEN_H = SCREEN_H_DEF,
  parameter int                 COLOR_W  = 3,
  parameter logic [COLOR_W-1:0] FG_COLOR = COLOR_W'(FG_COLOR_DEF),
  parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(BG_COLOR_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               plot,
  input  logic               s_color,
  input  logic [XW-1:0]      xpos,
  input  logic [YW-1:0]      ypos,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int                CELL_LOG     = $clog2(CELL);
  localparam int                CW           = (CELL > 1) ? CELL_LOG : 1;
  localparam logic [CW-1:0]     LAST         = CW'(CELL - 1);
  localparam logic [X_W:0]      SCREEN_X_LIM = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]      SCREEN_Y_LIM = (Y_W + 1)'(SCREEN_H);

  logic          pend_valid;
  logic          pend_color;
  logic [XW-1:0] pend_x;
  logic [YW-1:0] pend_y;
  logic          consume;
  logic          last_px;

  eng_state_e    state_q, state_d;
  logic [X_W:0]  base_x_q, base_x_d;
  logic [Y_W:0]  base_y_q, base_y_d;
  logic [CW-1:0] px_q, px_d;
  logic [CW-1:0] py_q, py_d;
  logic          fg_q, fg_d;

  logic [X_W-1:0]     vga_x_q, vga_x_d;
  logic [Y_W-1:0]     vga_y_q, vga_y_d;
  logic [COLOR_W-1:0] vga_colour_q, vga_colour_d;
  logic               vga_plot_q, vga_plot_d;
  logic               done_q, done_d;

  logic [X_W:0] pix_x;
  logic [Y_W:0] pix_y;
  logic         on_screen;
  logic         shape_on;

  plot_request_buffer #(
    .XW (XW),
    .YW (YW)
  ) u_pend (
    .clk        (clk),
    .reset      (reset),
    .plot       (plot),
    .s_color    (s_color),
    .xpos       (xpos),
    .ypos       (ypos),
    .consume    (consume),
    .pend_valid (pend_valid),
    .pend_color (pend_color),
    .pend_x     (pend_x),
    .pend_y     (pend_y),
    .overflow   (overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      base_x_q     <= '0;
      base_y_q     <= '0;
      px_q         <= '0;
      py_q         <= '0;
      fg_q         <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      px_q         <= px_d;
      py_q         <= py_d;
      fg_q         <= fg_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      done_q       <= done_d;
    end
  end

  always_comb begin : next_state
    last_px  = (state_q == DRAW) && (px_q == LAST) && (py_q == LAST);
    consume  = pend_valid && ((state_q == IDLE) || last_px);
    state_d  = state_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    px_d     = px_q;
    py_d     = py_q;
    fg_d     = fg_q;
    case (state_q)
      IDLE:    if (pend_valid) state_d = DRAW;
      DRAW:    if (last_px && !pend_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (consume) begin
      base_x_d = (X_W + 1)'(pend_x) << CELL_LOG;
      base_y_d = (Y_W + 1)'(pend_y) << CELL_LOG;
      px_d     = '0;
      py_d     = '0;
      fg_d     = pend_color;
    end else if (state_q == DRAW) begin
      if (px_q == LAST) begin
        px_d = '0;
        py_d = py_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  // Outputs are computed from next-state values so every pixel leaves a register.
  always_comb begin : outputs_comb
    pix_x     = base_x_d + (X_W + 1)'(px_d);
    pix_y     = base_y_d + (Y_W + 1)'(py_d);
    on_screen = (pix_x < SCREEN_X_LIM) && (pix_y < SCREEN_Y_LIM);
`ifdef SPRITE_PLOTTER_MASK_EN
    shape_on  = !fg_d || mask_bit(32'(px_d), 32'(py_d));
`else
    shape_on  = 1'b1;
`endif
    vga_x_d      = pix_x[X_W-1:0];
    vga_y_d      = pix_y[Y_W-1:0];
    vga_colour_d = fg_d ? FG_COLOR : BG_COLOR;
    vga_plot_d   = (state_d == DRAW) && on_screen && shape_on;
    done_d       = last_px;
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign done       = done_q;
  assign busy       = pend_valid || (state_q == DRAW);

endmodule
